ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds a shadow copy of the display value and rotates through the digits, one at a time.
- For the active digit it drives the 4-bit nibble into the registered hex-to-cathode decoder and asserts that digit's anode.
- Inserts a blanking guard between digits to absorb the decoder's one-cycle latency and prevent ghosting.
- Commits new display data only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot (blank + on).
- BLANK_CYCLES, 4: cycles per slot with all anodes off. Legal range: 2 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  reset, synchronous, active-high.
- i_Value  in  4*NUM_DIGITS  display nibbles; digit k = i_Value[4k+3:4k].
- i_Digit_En  in  NUM_DIGITS  per-digit enable; 0 = digit stays dark.
- i_DP  in  NUM_DIGITS  per-digit decimal point request, active-high.
- i_Load  in  1  one-cycle strobe; stages i_Value/i_Digit_En/i_DP.
- o_Num  out  4  nibble to the cathode decoder.
- o_Anodes  out  NUM_DIGITS  digit drive, active-low.
- o_DP  out  1  decimal point cathode, active-low.
- o_Pending  out  1  staged data not yet committed.
- o_Frame_Done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (i_RST high at a clock edge) sets:
  - o_Anodes all 1, o_Num 0, o_DP 1, o_Pending 0, o_Frame_Done 0.
  - Shadow and staging registers 0; digit index 0.
  - State BLANK; slot counter 0.
- Reset mid-scan aborts the slot immediately and discards any pending data.
- State BLANK:
  - Duration: BLANK_CYCLES cycles.
  - o_Anodes all 1.
  - o_Num = shadow nibble[idx], valid from the first BLANK cycle so the registered decoder settles.
  - o_DP = ~shadow_dp[idx].
  - Exit: BLANK -> ON.
- State ON:
  - Duration: REFRESH_DIV - BLANK_CYCLES cycles.
  - o_Anodes[idx] = ~shadow_en[idx]; all other anodes 1.
  - o_Num and o_DP are held.
  - Exit: ON -> BLANK with idx+1; idx wraps NUM_DIGITS-1 -> 0.
- Slot counter:
  - Width is clog2(REFRESH_DIV).
  - Resets to 0 on every state change; no free-running divider.
- All outputs are registered.
- Load and commit:
  - On i_Load, staging <= {i_Value, i_Digit_En, i_DP} and o_Pending <= 1.
  - A repeated load before commit overwrites staging (last load wins).
- Frame boundary = the edge leaving ON of digit NUM_DIGITS-1. On that edge:
  - o_Frame_Done <= 1 for exactly one cycle.
  - If pending: shadow <= staging and o_Pending <= 0.
  - In the following cycle, o_Num already reflects the new shadow digit 0.
- i_Load coincident with a frame boundary:
  - The previous staging contents are committed.
  - The new data is written to staging and o_Pending stays 1, so the new data commits at the next frame.
- A disabled digit still consumes its full slot (dark), keeping the refresh rate constant.
- Frame period = NUM_DIGITS * REFRESH_DIV cycles, exact and jitter-free.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles).
- Reset release, no load:
  - Cycles 0-1: anodes 1111.
  - Cycles 2-7: anodes 1110, o_Num 0.
  - Cycle 8: 1111.
  - Cycles 10-15: 1101.
  - o_Frame_Done high in cycle 32 only.
- i_Load at cycle 3 with i_Value 0x4321, en 1111, dp 0010:
  - o_Pending 1 from cycle 4 through cycle 31.
  - Cycle 32: o_Pending 0; o_Num shows 1, 2, 3, 4 in slots 0-3 of the second frame.
  - o_DP 0 only during slot 1.
- Loads at cycle 5 (0x1111) and cycle 20 (0x2222): the second frame displays 2222.
- Simultaneous load at cycle 31 (the frame-boundary edge) with 0xAAAA after a pending 0x5555:
  - Second frame shows 5555 and o_Pending stays 1.
  - Third frame shows AAAA.
- i_Digit_En = 0101 committed: anodes never drive digits 1 and 3 low; slot timing is unchanged (8 cycles each).
- i_RST asserted at cycle 12 (mid ON of digit 1) with data pending:
  - Next cycle: anodes 1111, o_Pending 0, idx 0.
  - The scan restarts with the cycle 0-7 pattern.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode
// seven-segment display. Each digit slot is a short blanking guard (anodes off,
// nibble presented early so the registered decoder settles) followed by the lit
// phase. New display data is staged on i_Load and committed only at the frame
// boundary so a frame never shows a mix of old and new digits.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    input  logic [NUM_DIGITS-1:0]   i_DP,
    input  logic                    i_Load,
    output logic [3:0]              o_Num,
    output logic [NUM_DIGITS-1:0]   o_Anodes,
    output logic                    o_DP,
    output logic                    o_Pending,
    output logic                    o_Frame_Done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    // Last counter value of each phase; the counter restarts on every phase change.
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [IW-1:0]           idx_reg, idx_next;

    logic [4*NUM_DIGITS-1:0] shadow_val_reg, shadow_val_next;
    logic [NUM_DIGITS-1:0]   shadow_en_reg, shadow_en_next;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
    logic [4*NUM_DIGITS-1:0] stage_val_reg, stage_val_next;
    logic [NUM_DIGITS-1:0]   stage_en_reg, stage_en_next;
    logic [NUM_DIGITS-1:0]   stage_dp_reg, stage_dp_next;
    logic                    pending_reg, pending_next;

    logic [3:0]              num_reg, num_next;
    logic [NUM_DIGITS-1:0]   anodes_reg, anodes_next;
    logic                    dp_reg, dp_next;
    logic                    frame_done_reg, frame_done_next;

    logic                    slot_end;
    logic                    frame_end;

    // Nibble view of the next shadow value, one entry per digit.
    logic [3:0]              nib_next [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib_next[gi] = shadow_val_next[4*gi +: 4];
        end
    endgenerate

    // State register plus all registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_reg      <= ST_BLANK;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shadow_val_reg <= '0;
            shadow_en_reg  <= '0;
            shadow_dp_reg  <= '0;
            stage_val_reg  <= '0;
            stage_en_reg   <= '0;
            stage_dp_reg   <= '0;
            pending_reg    <= 1'b0;
            num_reg        <= 4'h0;
            anodes_reg     <= '1;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shadow_val_reg <= shadow_val_next;
            shadow_en_reg  <= shadow_en_next;
            shadow_dp_reg  <= shadow_dp_next;
            stage_val_reg  <= stage_val_next;
            stage_en_reg   <= stage_en_next;
            stage_dp_reg   <= stage_dp_next;
            pending_reg    <= pending_next;
            num_reg        <= num_next;
            anodes_reg     <= anodes_next;
            dp_reg         <= dp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Slot sequencing, staging/commit, and next values of the output registers.
    // Outputs are derived from the *next* state so they line up with it exactly.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = idx_reg;
        shadow_val_next = shadow_val_reg;
        shadow_en_next  = shadow_en_reg;
        shadow_dp_next  = shadow_dp_reg;
        stage_val_next  = stage_val_reg;
        stage_en_next   = stage_en_reg;
        stage_dp_next   = stage_dp_reg;
        pending_next    = pending_reg;
        anodes_next     = '1;

        slot_end  = (state_reg == ST_BLANK) ? (cnt_reg == BLANK_LAST)
                                            : (cnt_reg == ON_LAST);
        frame_end = (state_reg == ST_ON) && slot_end && (idx_reg == IDX_LAST);

        if (slot_end) begin
            cnt_next = '0;
            if (state_reg == ST_BLANK) begin
                state_next = ST_ON;
            end else begin
                state_next = ST_BLANK;
                idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
        end

        // Commit old staging first; a coincident load then refills staging
        // and keeps the pending flag up for the following frame.
        if (frame_end && pending_reg) begin
            shadow_val_next = stage_val_reg;
            shadow_en_next  = stage_en_reg;
            shadow_dp_next  = stage_dp_reg;
            pending_next    = 1'b0;
        end
        if (i_Load) begin
            stage_val_next = i_Value;
            stage_en_next  = i_Digit_En;
            stage_dp_next  = i_DP;
            pending_next   = 1'b1;
        end

        frame_done_next = frame_end;
        num_next        = nib_next[idx_next];
        dp_next         = ~shadow_dp_next[idx_next];
        if (state_next == ST_ON) begin
            anodes_next[idx_next] = ~shadow_en_next[idx_next];
        end
    end

    assign o_Num        = num_reg;
    assign o_Anodes     = anodes_reg;
    assign o_DP         = dp_reg;
    assign o_Pending    = pending_reg;
    assign o_Frame_Done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl (4 digits, 8-cycle slots,
// 2 blank cycles). The driver advances a time-based reference model each cycle
// and queues the expected outputs; the monitor compares after every clock edge.
module tb_ssd_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*ND-1:0] value = '0;
    logic [ND-1:0]   digit_en = '0;
    logic [ND-1:0]   dp_in = '0;
    logic            load = 1'b0;
    logic [3:0]      num;
    logic [ND-1:0]   anodes;
    logic            dp_out;
    logic            pending;
    logic            frame_done;

    ssd_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_Value      (value),
        .i_Digit_En   (digit_en),
        .i_DP         (dp_in),
        .i_Load       (load),
        .o_Num        (num),
        .o_Anodes     (anodes),
        .o_DP         (dp_out),
        .o_Pending    (pending),
        .o_Frame_Done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [3:0] nm;
        logic       dp;
        logic       pd;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: time since reset plus committed / staged data.
    int          m_t = 0;
    logic [15:0] m_sv = '0, m_stv = '0;
    logic [3:0]  m_se = '0, m_sd = '0, m_ste = '0, m_std = '0;
    bit          m_pend = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        int   slot, pos;
        slot   = (m_t % FR) / RD;
        pos    = m_t % RD;
        e.t    = m_t;
        e.an   = 4'hF;
        if (pos >= BC) e.an[slot] = ~m_se[slot];
        e.nm   = m_sv[slot*4 +: 4];
        e.dp   = ~m_sd[slot];
        e.pd   = m_pend;
        e.fd   = (m_t != 0) && (m_t % FR == 0);
        return e;
    endfunction

    // One clock cycle: present inputs, advance the model across the edge, queue expectation.
    task automatic cyc(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] e, input logic [3:0] d);
        @(negedge clk);
        rst = r; load = ld; value = v; digit_en = e; dp_in = d;
        if (ld && !r)
            $display("load   t=%0d value=%h en=%b dp=%b", m_t, v, e, d);
        if (r) begin
            m_t = 0; m_pend = 0;
            m_sv = '0; m_se = '0; m_sd = '0; m_stv = '0; m_ste = '0; m_std = '0;
        end else begin
            if ((m_t % FR == FR - 1) && m_pend) begin
                m_sv = m_stv; m_se = m_ste; m_sd = m_std; m_pend = 0;
            end
            if (ld) begin
                m_stv = v; m_ste = e; m_std = d; m_pend = 1;
            end
            m_t++;
        end
        q.push_back(model_out());
    endtask

    task automatic idle_until(input int target);
        while (m_t < target) cyc(0, 0, $urandom, 4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        cyc(1, 0, '0, '0, '0);
        cyc(1, 0, '0, '0, '0);
    endtask

    // Monitor: compare every output against the queued expectation after each edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (anodes !== e.an || num !== e.nm || dp_out !== e.dp ||
                    pending !== e.pd || frame_done !== e.fd) begin
                    n_err++;
                    $display("FAIL scan t=%0d: got an=%b num=%h dp=%b pend=%b fd=%b, want an=%b num=%h dp=%b pend=%b fd=%b",
                             e.t, anodes, num, dp_out, pending, frame_done,
                             e.an, e.nm, e.dp, e.pd, e.fd);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        do_reset();

        // Reset values against fixed constants.
        @(posedge clk); #2;
        n_cmp++;
        if (anodes !== 4'hF || num !== 4'h0 || dp_out !== 1'b1 ||
            pending !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got an=%b num=%h dp=%b pend=%b fd=%b, want an=1111 num=0 dp=1 pend=0 fd=0",
                     anodes, num, dp_out, pending, frame_done);
        end

        // Single load mid-frame, committed at the first boundary.
        do_reset();
        idle_until(3);
        cyc(0, 1, 16'h4321, 4'b1111, 4'b0010);
        idle_until(70);

        // Two loads before a boundary: last one wins.
        do_reset();
        idle_until(5);
        cyc(0, 1, 16'h1111, 4'b1111, 4'b0000);
        idle_until(20);
        cyc(0, 1, 16'h2222, 4'b1111, 4'b0000);
        idle_until(70);

        // Load coincident with the boundary edge while data is pending.
        do_reset();
        idle_until(3);
        cyc(0, 1, 16'h5555, 4'b1111, 4'b0000);
        idle_until(31);
        cyc(0, 1, 16'hAAAA, 4'b1111, 4'b0000);
        idle_until(100);

        // Disabled digits stay dark while keeping slot timing.
        do_reset();
        idle_until(4);
        cyc(0, 1, 16'h9876, 4'b0101, 4'b1111);
        idle_until(70);

        // Reset mid ON slot of digit 1 with data pending.
        do_reset();
        idle_until(3);
        cyc(0, 1, 16'hBEEF, 4'b1111, 4'b1001);
        idle_until(12);
        cyc(1, 0, '0, '0, '0);
        idle_until(40);

        // Randomized traffic, with extra loads aimed at frame-boundary edges.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r, ld;
            r  = ($urandom_range(0, 499) == 0);
            ld = (m_t % FR == FR - 1) ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 7) == 0);
            cyc(r, ld, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        load = 1'b0;
        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
